// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: dead-time blanking, invalid-digit masking, adjust-mode blink.
// Optional macro LEADING_ZERO_BLANK_EN hides a zero minutes-tens digit.
module seg_scan_ctrl #(
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_tick,
    input  logic       blink_tick,
    input  logic       adj,
    input  logic       sel,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    output logic [3:0] display_state,
    output logic [3:0] anode,
    output logic [1:0] digit_idx
);

    localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             invalid;
    logic             primed;
    logic             blink_phase;
    logic [1:0]       next_idx;
    logic [3:0]       next_val;
    logic [3:0]       cur_val;
    logic             suppress;

    assign next_idx = digit_idx + 2'd1;

    always_comb begin
        next_val = digit0;
        case (next_idx)
            2'd0: next_val = digit0;
            2'd1: next_val = digit1;
            2'd2: next_val = digit2;
            2'd3: next_val = digit3;
            default: next_val = digit0;
        endcase
    end

    always_comb begin
        cur_val = digit0;
        case (digit_idx)
            2'd0: cur_val = digit0;
            2'd1: cur_val = digit1;
            2'd2: cur_val = digit2;
            2'd3: cur_val = digit3;
            default: cur_val = digit0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= BLANK;
            cnt           <= CNT_LOAD;
            digit_idx     <= 2'd0;
            display_state <= 4'd0;
            invalid       <= 1'b0;
            primed        <= 1'b0;
            blink_phase   <= 1'b0;
        end else begin
            blink_phase <= adj ? (blink_phase ^ blink_tick) : 1'b0;
            case (state)
                BLANK: begin
                    if (cnt == '0) begin
                        state <= SHOW;
                        // Reset forces display_state to 0, so digit 0 of the very first scan is loaded here instead.
                        if (!primed) begin
                            primed        <= 1'b1;
                            invalid       <= (cur_val > 4'd9);
                            display_state <= (cur_val > 4'd9) ? 4'd0 : cur_val;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SHOW: begin
                    if (scan_tick) begin
                        state         <= BLANK;
                        cnt           <= CNT_LOAD;
                        digit_idx     <= next_idx;
                        invalid       <= (next_val > 4'd9);
                        display_state <= (next_val > 4'd9) ? 4'd0 : next_val;
                    end
                end
                default: state <= BLANK;
            endcase
        end
    end

    // Blink masking is combinational so adj/sel changes act mid-SHOW.
    always_comb begin
        suppress = invalid | (adj & blink_phase & (digit_idx[1] == sel));
`ifdef LEADING_ZERO_BLANK_EN
        if (digit_idx == 2'd3 && display_state == 4'd0)
            suppress = 1'b1;
`endif
        anode = 4'b1111;
        if (state == SHOW && !suppress)
            anode = ~(4'b0001 << digit_idx);
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected SHOW results queued at each scan, popped when the new digit lights.
module tb_seg_scan_ctrl;

    localparam int BLANK_CYCLES = 4;

    typedef struct {
        logic [1:0] idx;
        logic [3:0] ds;
        logic [3:0] an;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scan_tick = 1'b0;
    logic       blink_tick = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] dig [4];
    logic [3:0] display_state;
    logic [3:0] anode;
    logic [1:0] digit_idx;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [1:0] exp_idx = 2'd0;
    logic       exp_phase = 1'b0;

    seg_scan_ctrl #(.BLANK_CYCLES(BLANK_CYCLES)) dut (
        .clk(clk), .rst(rst), .scan_tick(scan_tick), .blink_tick(blink_tick),
        .adj(adj), .sel(sel),
        .digit0(dig[0]), .digit1(dig[1]), .digit2(dig[2]), .digit3(dig[3]),
        .display_state(display_state), .anode(anode), .digit_idx(digit_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_ds(input logic [1:0] idx);
        return (dig[idx] > 4'd9) ? 4'd0 : dig[idx];
    endfunction

    function automatic logic [3:0] exp_an(input logic [1:0] idx);
        logic sup;
        sup = (dig[idx] > 4'd9) || (adj && exp_phase && (idx[1] == sel));
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 2'd3 && dig[3] == 4'd0) sup = 1'b1;
`endif
        return sup ? 4'b1111 : ~(4'b0001 << idx);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp();
        exp_t e;
        e.idx = exp_idx;
        e.ds  = exp_ds(exp_idx);
        e.an  = exp_an(exp_idx);
        sb.push_back(e);
    endtask

    // Walk the blank window (optionally poking scan_tick into it) and pop the expected SHOW.
    task automatic await_show(input bit extra);
        exp_t e;
        for (int k = 1; k < BLANK_CYCLES; k++) begin
            if (extra) scan_tick = 1'b1;
            step();
            scan_tick = 1'b0;
            chk("blank_hold", anode, 4'b1111);
        end
        step();
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("show_anode", anode, e.an);
            chk("show_idx", digit_idx, e.idx);
            chk("show_ds", display_state, e.ds);
        end
    endtask

    task automatic dwell(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            chk("dwell_anode", anode, exp_an(exp_idx));
        end
    endtask

    task automatic scan_next(input bit extra);
        exp_idx = exp_idx + 2'd1;
        scan_tick = 1'b1;
        step();
        scan_tick = 1'b0;
        chk("enter_blank", anode, 4'b1111);
        chk("enter_idx", digit_idx, exp_idx);
        chk("enter_ds", display_state, exp_ds(exp_idx));
        push_exp();
        await_show(extra);
        dwell(14);
    endtask

    task automatic blink_pulse();
        blink_tick = 1'b1;
        step();
        blink_tick = 1'b0;
        exp_phase = ~exp_phase;
        chk("blink_anode", anode, exp_an(exp_idx));
    endtask

    always @(negedge clk)
        chk("no_overlap", ($countones(~anode) <= 1), 1);

    initial begin
        dig[0] = 4'd9; dig[1] = 4'd5; dig[2] = 4'd2; dig[3] = 4'd1;
        step();
        step();
        chk("rst_anode", anode, 4'b1111);
        chk("rst_idx", digit_idx, 2'd0);
        chk("rst_ds", display_state, 4'd0);

        // Basic rotation from reset
        rst = 1'b0;
        exp_idx = 2'd0;
        push_exp();
        await_show(1'b0);
        dwell(15);
        for (int i = 0; i < 4; i++) scan_next(1'b0);

        // Ticks inside the blank window are ignored
        for (int i = 0; i < 4; i++) scan_next(1'b1);

        // Invalid digit value
        dig[1] = 4'hC;
        for (int i = 0; i < 4; i++) scan_next(1'b0);
        dig[1] = 4'd5;

        // Blink on the minutes pair
        adj = 1'b1;
        sel = 1'b1;
        for (int i = 0; i < 3; i++) scan_next(1'b0);
        blink_pulse();
        chk("blink_on_d3", anode, 4'b1111);
        for (int i = 0; i < 4; i++) scan_next(1'b0);
        blink_pulse();
        chk("blink_off_d3", anode, 4'b0111);
        blink_pulse();
        adj = 1'b0;
        #1;
        chk("adj_drop_comb", anode, 4'b0111);
        exp_phase = 1'b0;
        step();
        adj = 1'b1;
        #1;
        chk("phase_cleared", anode, 4'b0111);
        adj = 1'b0;
        step();

        // Reset mid-SHOW on digit 2
        for (int i = 0; i < 3; i++) scan_next(1'b0);
        chk("on_digit2", digit_idx, 2'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_anode", anode, 4'b1111);
        chk("midrst_idx", digit_idx, 2'd0);
        chk("midrst_ds", display_state, 4'd0);
        exp_idx = 2'd0;
        push_exp();
        await_show(1'b0);
        dwell(10);

        // Zero in the minutes-tens position
        dig[3] = 4'd0;
        for (int i = 0; i < 3; i++) scan_next(1'b0);
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_anode", anode, 4'b1111);
`else
        chk("lz_anode", anode, 4'b0111);
`endif
        chk("lz_ds", display_state, 4'd0);
        scan_next(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing controller for the stopwatch's four-digit seven-segment display. It rotates through the digits and drives the active-low anodes. For each digit it presents the 4-bit value on `display_state`, which feeds the cathode decoder. It inserts a dead-time blank between digits to suppress ghosting, and it blinks the digit pair being adjusted in adjust mode.

## Interface
- `BLANK_CYCLES`, default 4: number of `clk` cycles all anodes are held off between digits. Must be ≥1.
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `scan_tick` input 1: one-cycle pulse that advances to the next digit (~1 kHz rate).
- `blink_tick` input 1: one-cycle pulse that toggles the blink phase (~2 Hz rate).
- `adj` input 1: adjust mode enable.
- `sel` input 1: pair being adjusted. 0 = seconds (digits 1:0), 1 = minutes (digits 3:2).
- `digit0`..`digit3` input 4 each: BCD values. `digit0` is rightmost (seconds ones); `digit3` is leftmost (minutes tens).
- `display_state` output 4: value of the current digit, sent to the cathode decoder.
- `anode` output 4: active-low digit enables. `anode[i]` drives digit i.
- `digit_idx` output 2: index of the current or pending digit.

## Operation
- Two-state FSM:
  - BLANK: counter runs; `anode`=4'b1111.
  - SHOW: `anode` = ~(1<<`digit_idx`), unless the digit is suppressed.
- BLANK → SHOW: when the counter reaches 0.
- SHOW → BLANK: on `scan_tick`.
  - On that edge, `digit_idx` ← `digit_idx`+1 mod 4 (3 wraps to 0).
  - `display_state` ← `digit[new idx]`, registered and held until the next transition.
  - The counter loads `BLANK_CYCLES`-1.
- `scan_tick` during BLANK is ignored; no queuing.
- Digit values 10–15: `display_state` is forced to 0 and that digit's anode stays high for the whole SHOW. The decoder never receives an undecoded value.
- Blink phase:
  - Flips on `blink_tick` while `adj`=1.
  - Cleared to 0 on any cycle with `adj`=0.
- Blink suppression: while `adj`=1 and the blink phase is 1, digits in the `sel` pair keep their anodes high during SHOW.
  - Evaluated combinationally from the current phase, `adj` and `sel`.
  - Takes effect mid-SHOW without waiting for the next scan.
- Simultaneous `scan_tick` and `blink_tick`: both take effect on the same edge.
- `rst` asserted mid-scan wins over every other input on that edge.

## Timing
- Reset values:
  - FSM = BLANK, counter = `BLANK_CYCLES`-1, `digit_idx`=0.
  - `display_state`=0, blink phase 0, `anode`=4'b1111.
  - The first SHOW (digit 0) begins `BLANK_CYCLES` cycles after `rst` deasserts.
- `scan_tick` sampled high at edge N, in SHOW:
  - From edge N: `anode`=1111 and the new `display_state`/`digit_idx` are valid.
  - The new anode goes low at edge N+`BLANK_CYCLES`.
- `display_state` is stable for the entire BLANK+SHOW window of its digit. Digit inputs are sampled only at BLANK entry.
- Blink change latency: `blink_tick` or `adj` at edge N changes `anode` from edge N (registered phase) or immediately (`adj`/`sel` combinational).
- `anode` is never low for two digits in the same cycle.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: when `digit3`==0, `anode[3]` stays high in SHOW. This keeps "05:30" displayed as " 5:30". Blink and invalid-digit rules still apply to the other digits.
- Not defined: all four digits are shown regardless of value. The extra comparator is not compiled.

## Test plan
- Reset, `BLANK_CYCLES`=4, digits 3..0 = 1,2,5,9, `scan_tick` every 20 cycles:
  - `anode` goes 1111 → 1110 (display_state 9) → 1111 ×4 → 1101 (5) → 1011 (2) → 0111 (1) → 1110.
  - No overlapping lows.
- Extra `scan_tick` pulses inside the BLANK window: no index skip; the sequence is identical to the previous test.
- `digit1`=4'hC: `display_state`=0 and `anode[1]` stays high for that digit's SHOW; the other digits are unaffected.
- `adj`=1, `sel`=1, then a `blink_tick`: `anode[3:2]` stay high while `anode[1:0]` still scan. A second `blink_tick` restores them. Dropping `adj` clears the phase immediately.
- `rst` pulsed mid-SHOW on digit 2: next edge `anode`=1111, `digit_idx`=0, `display_state`=0.
- With `LEADING_ZERO_BLANK_EN`, `digit3`=0: `anode[3]` never low. Without it: digit 3 is shown with `display_state`=0.
